// File: rtl/bram_self_clear.sv
// Single-port BRAM that zero-fills every entry after reset, then serves 1-cycle-latency reads/writes.
// Define BRAM_CLEAR_WRITE_FIRST_EN for write-first read-during-write; read-first otherwise.
module bram_self_clear #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 1024,
    parameter int unsigned ADDR_LSH = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    output logic             o_initialized,
    input  logic             i_request,
    input  logic             i_rw,
    input  logic [31:0]      i_address,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_ready
);

    localparam int unsigned IDX_W = $clog2(SIZE);

`ifdef BRAM_CLEAR_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_q, clr_d;
    logic             init_q, init_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] mem_q [SIZE];
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [IDX_W-1:0] idx;

    // Upper address bits beyond the index are dropped, so addresses wrap.
    assign idx = IDX_W'(i_address >> ADDR_LSH);

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        init_d    = init_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_addr  = idx;
        mem_wdata = i_wdata;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + 1'b1;
                rdata_d   = '0;
                init_d    = 1'b0;
                if (clr_q == IDX_W'(SIZE - 1)) begin
                    state_d = ST_READY;
                    init_d  = 1'b1;
                end
            end
            default: begin
                init_d = 1'b1;
                if (i_request) begin
                    mem_we  = i_rw;
                    ready_d = 1'b1;
                    if (WRITE_FIRST && i_rw)
                        rdata_d = i_wdata;
                    else
                        rdata_d = mem_q[idx];
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
            init_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            init_q  <= init_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is left untouched while reset is held.
    always_ff @(posedge i_clock) begin
        if (i_reset && mem_we)
            mem_q[mem_addr] <= mem_wdata;
    end

    assign o_initialized = init_q;
    assign o_ready       = ready_q;
    assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_bram_self_clear.sv
// Self-checking bench for bram_self_clear (SIZE=16): vector table plus scoreboard queue of read data.
module tb_bram_self_clear;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SIZE  = 16;

`ifdef BRAM_CLEAR_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic             i_clock;
    logic             i_reset;
    logic             o_initialized;
    logic             i_request;
    logic             i_rw;
    logic [31:0]      i_address;
    logic [WIDTH-1:0] i_wdata;
    logic [WIDTH-1:0] o_rdata;
    logic             o_ready;

    bram_self_clear #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_LSH(2)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .o_initialized(o_initialized),
        .i_request    (i_request),
        .i_rw         (i_rw),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_ready      (o_ready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] exp_q[$];
    logic [31:0] mdl[SIZE];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wexp(input logic [31:0] old_v, input logic [31:0] new_v);
        return WF ? new_v : old_v;
    endfunction

    // One cycle: drive inputs, clock, then compare registered outputs against the scoreboard.
    task automatic apply(input bit req, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] e;
        i_request = req;
        i_rw      = rw;
        i_address = addr;
        i_wdata   = wd;
        if (req) exp_q.push_back(exp);
        @(posedge i_clock);
        #1;
        i_request = 1'b0;
        i_rw      = 1'b0;
        chk("ready", {31'b0, o_ready}, {31'b0, req});
        if (o_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: ready=1 with no pending request");
            end else begin
                e = exp_q.pop_front();
                chk("rdata", o_rdata, e);
            end
        end
    endtask

    task automatic clear_sweep(input bit poke);
        for (int k = 1; k <= 16; k++) begin
            i_request = poke;
            i_rw      = 1'b1;
            i_address = 32'h0C;
            i_wdata   = 32'h55;
            @(posedge i_clock);
            #1;
            chk("clr_init", {31'b0, o_initialized}, {31'b0, (k == 16)});
            chk("clr_ready", {31'b0, o_ready}, 32'd0);
            if (k < 16) chk("clr_rdata", o_rdata, 32'd0);
        end
        i_request = 1'b0;
        i_rw      = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 32'(i * 4), 32'd0, 32'd0);
    endtask

    initial begin
        i_reset   = 1'b0;
        i_request = 1'b0;
        i_rw      = 1'b0;
        i_address = '0;
        i_wdata   = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, wexp(32'h0, 32'hDEADBEEF)};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h40, 32'h11,       wexp(32'h0, 32'h11)};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,        32'h11};
        vecs[4]  = '{1'b1, 32'h14, 32'hA,        wexp(32'h0, 32'hA)};
        vecs[5]  = '{1'b1, 32'h14, 32'hB,        wexp(32'hA, 32'hB)};
        vecs[6]  = '{1'b0, 32'h14, 32'h0,        32'hB};
        vecs[7]  = '{1'b0, 32'h0C, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 32'h3C, 32'hCAFE,     wexp(32'h0, 32'hCAFE)};
        vecs[9]  = '{1'b0, 32'hFC, 32'h0,        32'hCAFE};
        vecs[10] = '{1'b0, 32'h48, 32'h0,        32'hDEADBEEF};

        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_init", {31'b0, o_initialized}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);

        i_reset = 1'b1;
        clear_sweep(1'b1);
        read_all_zero();

        foreach (vecs[i]) begin
            apply(1'b1, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
            if (vecs[i].rw) mdl[(vecs[i].addr >> 2) % SIZE] = vecs[i].wdata;
        end

        apply(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("idle_hold", o_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b1, 32'(i * 4), 32'h100 + 32'(i), wexp(mdl[i], 32'h100 + 32'(i)));
            mdl[i] = 32'h100 + 32'(i);
        end
        apply(1'b1, 1'b0, 32'h1C, 32'h0, 32'h107);

        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        chk("rst2_init", {31'b0, o_initialized}, 32'd0);
        chk("rst2_ready", {31'b0, o_ready}, 32'd0);
        chk("rst2_rdata", o_rdata, 32'd0);
        i_reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clock);
            #1;
            chk("part_init", {31'b0, o_initialized}, 32'd0);
        end
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        clear_sweep(1'b0);
        read_all_zero();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
